// File: rtl/task_2_manager.sv
// Manager-side end of both task_2 streaming ports: buffers one loader packet,
// streams it into task_2 and folds the answer stream into one result per packet.
module task_2_manager #(
  parameter int MAX_BYTES      = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_src_valid,
  input  logic [7:0]  i_src_data,
  input  logic        i_src_last,
  output logic        o_src_ready,
  output logic        o_tdata_valid,
  output logic [7:0]  o_tdata,
  output logic        o_tdata_last,
  input  logic        i_tready,
  input  logic        i_tanswer_ready,
  input  logic [7:0]  i_tanswer_data,
  input  logic        i_tanswer_data_last,
  input  logic [11:0] i_packet_size_in_bytes,
  output logic        o_tmanager_ready,
  output logic        o_result_valid,
  output logic [11:0] o_tx_count,
  output logic [11:0] o_rx_count,
  output logic [7:0]  o_checksum,
  output logic        o_size_mismatch,
  output logic        o_overflow,
  output logic        o_timeout
);
  // state   | meaning
  // IDLE    | waiting for the first loader byte
  // LOAD    | filling the buffer
  // PREP    | prefetch byte 0, clear answer tallies
  // SEND    | streaming buffer out, answer accepted in parallel
  // WAIT_RX | send finished, waiting for answer last or timeout
  // REPORT  | one-cycle result strobe

  localparam int AW = $clog2(MAX_BYTES);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PREP, SEND, WAIT_RX, REPORT} state_t;

  state_t        state;
  logic [7:0]    mem [MAX_BYTES];
  logic [LW-1:0] wr_ptr, rd_ptr, len, tx_cnt;
  logic [11:0]   rx_cnt, size_q;
  logic [7:0]    cks;
  logic          rx_done, ovf;
  logic [TW-1:0] tmo_cnt;

  logic          src_fire, tx_fire, rx_fire, rx_last_fire, send_done;
  logic          go_report, timeout_hit, rd_en, mem_we;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rx_cnt_nxt, size_nxt, tx_sat;
  logic [7:0]    cks_nxt;
  logic [LW-1:0] tx_cnt_nxt;
  logic [12:0]   tx_wide;

  always_comb begin
    src_fire     = i_src_valid && o_src_ready;
    tx_fire      = o_tdata_valid && i_tready;
    rx_fire      = i_tanswer_ready && o_tmanager_ready;
    rx_last_fire = rx_fire && i_tanswer_data_last;
    send_done    = tx_fire && o_tdata_last;
    mem_we       = src_fire && !wr_ptr[AW];

    rx_cnt_nxt = rx_cnt;
    cks_nxt    = cks;
    if (rx_fire) begin
      if (rx_cnt != 12'hFFF) rx_cnt_nxt = rx_cnt + 12'd1;
      cks_nxt = cks ^ i_tanswer_data;
    end
    size_nxt   = rx_last_fire ? i_packet_size_in_bytes : size_q;
    tx_cnt_nxt = tx_fire ? tx_cnt + 1'b1 : tx_cnt;
    tx_wide    = 13'(tx_cnt_nxt);
    tx_sat     = tx_wide[12] ? 12'hFFF : tx_wide[11:0];

    // Results are loaded on the edge into REPORT, so they use next-cycle tallies.
    timeout_hit = (state == WAIT_RX) && !rx_done && !rx_fire && (tmo_cnt == '0);
    go_report   = ((state == SEND) && send_done && (rx_done || rx_last_fire)) ||
                  ((state == WAIT_RX) && (rx_done || rx_last_fire || timeout_hit));

    rd_en   = 1'b0;
    rd_addr = rd_ptr[AW-1:0];
    if (state == PREP) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (state == SEND) begin
      rd_en = 1'b1;
      if (tx_fire) rd_addr = AW'(rd_ptr + 1'b1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= i_src_data;
  end

  // Re-reading rd_ptr while stalled keeps o_tdata stable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      o_tdata <= '0;
    else if (rd_en) o_tdata <= mem[rd_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      len              <= '0;
      tx_cnt           <= '0;
      rx_cnt           <= '0;
      size_q           <= '0;
      cks              <= '0;
      rx_done          <= 1'b0;
      ovf              <= 1'b0;
      tmo_cnt          <= '0;
      o_src_ready      <= 1'b0;
      o_tdata_valid    <= 1'b0;
      o_tdata_last     <= 1'b0;
      o_tmanager_ready <= 1'b0;
      o_result_valid   <= 1'b0;
      o_tx_count       <= '0;
      o_rx_count       <= '0;
      o_checksum       <= '0;
      o_size_mismatch  <= 1'b0;
      o_overflow       <= 1'b0;
      o_timeout        <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      if (rx_fire) begin
        rx_cnt  <= rx_cnt_nxt;
        cks     <= cks_nxt;
        tmo_cnt <= TMO_RELOAD;
      end
      if (rx_last_fire) begin
        size_q           <= i_packet_size_in_bytes;
        rx_done          <= 1'b1;
        o_tmanager_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          o_src_ready <= 1'b1;
          if (src_fire) begin
            wr_ptr <= LW'(1);
            if (i_src_last) begin
              len         <= LW'(1);
              o_src_ready <= 1'b0;
              state       <= PREP;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (src_fire) begin
            if (!wr_ptr[AW]) wr_ptr <= wr_ptr + 1'b1;
            else             ovf    <= 1'b1;
            if (i_src_last) begin
              len         <= wr_ptr[AW] ? wr_ptr : wr_ptr + 1'b1;
              o_src_ready <= 1'b0;
              state       <= PREP;
            end
          end
        end
        PREP: begin
          rd_ptr           <= '0;
          tx_cnt           <= '0;
          rx_cnt           <= '0;
          cks              <= '0;
          size_q           <= '0;
          rx_done          <= 1'b0;
          tmo_cnt          <= TMO_RELOAD;
          o_tdata_valid    <= 1'b1;
          o_tdata_last     <= (len == LW'(1));
          o_tmanager_ready <= 1'b1;
          state            <= SEND;
        end
        SEND: begin
          if (tx_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            tx_cnt <= tx_cnt_nxt;
            if (o_tdata_last) begin
              o_tdata_valid <= 1'b0;
              o_tdata_last  <= 1'b0;
              state         <= go_report ? REPORT : WAIT_RX;
            end else begin
              o_tdata_last <= (rd_ptr + LW'(2) == len);
            end
          end
        end
        WAIT_RX: begin
          if (go_report)     state   <= REPORT;
          else if (!rx_fire) tmo_cnt <= tmo_cnt - 1'b1;
        end
        REPORT: begin
          state       <= IDLE;
          o_src_ready <= 1'b1;
          wr_ptr      <= '0;
          ovf         <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (go_report) begin
        o_result_valid   <= 1'b1;
        o_tmanager_ready <= 1'b0;
        o_tx_count       <= tx_sat;
        o_rx_count       <= rx_cnt_nxt;
        o_checksum       <= cks_nxt;
        o_size_mismatch  <= !timeout_hit && (rx_cnt_nxt != size_nxt);
        o_overflow       <= ovf;
        o_timeout        <= timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_task_2_manager.sv
// Bench for task_2_manager: table-driven packets, reset corner cases and
// randomized packets checked against a packet-level reference model.
module tb_task_2_manager;
  localparam int MAXB = 16;
  localparam int TMO  = 10;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int len; int base; int mode; int delay; int gap;
    int n_ans; logic [31:0] ans; int size;
    int e_tx; int e_rx; int e_cks; int e_mis; int e_ovf; int e_tmo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0, src_last = 1'b0, tready = 1'b0;
  logic [7:0]  src_data = '0, ans_data = '0;
  logic        ans_valid = 1'b0, ans_last_in = 1'b0;
  logic [11:0] ans_size = '0;

  logic        o_src_ready, o_tdata_valid, o_tdata_last, o_tmanager_ready;
  logic        o_result_valid, o_size_mismatch, o_overflow, o_timeout;
  logic [7:0]  o_tdata, o_checksum;
  logic [11:0] o_tx_count, o_rx_count;

  task_2_manager #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_src_valid(src_valid), .i_src_data(src_data), .i_src_last(src_last),
    .o_src_ready(o_src_ready),
    .o_tdata_valid(o_tdata_valid), .o_tdata(o_tdata), .o_tdata_last(o_tdata_last),
    .i_tready(tready),
    .i_tanswer_ready(ans_valid), .i_tanswer_data(ans_data),
    .i_tanswer_data_last(ans_last_in), .i_packet_size_in_bytes(ans_size),
    .o_tmanager_ready(o_tmanager_ready), .o_result_valid(o_result_valid),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_checksum(o_checksum),
    .o_size_mismatch(o_size_mismatch), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;
  bq_t cur_d, cur_a;
  int  load_last, send_last, ans_last_cyc, first_cyc, res_cyc, nsent;
  bit  loaded, done, res_seen;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int outs_nonzero();
    return int'(|{o_src_ready, o_tdata_valid, o_tdata, o_tdata_last, o_tmanager_ready,
                  o_result_valid, o_tx_count, o_rx_count, o_checksum, o_size_mismatch,
                  o_overflow, o_timeout});
  endfunction

  task automatic load_bytes(input bq_t d);
    for (int i = 0; i < d.size(); i++) begin
      int w;
      w = 0;
      src_valid = 1'b1; src_data = d[i]; src_last = (i == d.size() - 1);
      do begin @(negedge clk); w++; end while (!o_src_ready && w < 200);
      if (src_last) begin load_last = cyc; loaded = 1'b1; end
      @(posedge clk); #1;
    end
    src_valid = 1'b0; src_last = 1'b0;
  endtask

  // Packet-level reference: what the spec's rules say the result must be.
  task automatic model(input bq_t d, input bq_t a, input int size,
                       output int tx, output int rx, output int cks,
                       output int mis, output int ovf, output int tmo);
    tx  = (d.size() < MAXB) ? d.size() : MAXB;
    ovf = (d.size() > MAXB) ? 1 : 0;
    tmo = (a.size() == 0) ? 1 : 0;
    rx  = a.size();
    cks = 0;
    foreach (a[i]) cks = cks ^ int'(a[i]);
    mis = (tmo == 0 && rx != size) ? 1 : 0;
  endtask

  task automatic run_pkt(input bq_t d, input bq_t a, input int size, input int mode,
                         input int delay, input int gap, input int e_tx, input int e_rx,
                         input int e_cks, input int e_mis, input int e_ovf, input int e_tmo);
    int exp_res;
    @(posedge clk); #1;
    cur_d = d; cur_a = a; ans_size = 12'(size);
    loaded = 0; done = 0; res_seen = 0;
    load_last = -1; send_last = -1; ans_last_cyc = -1; first_cyc = -1; res_cyc = -1; nsent = 0;
    fork
      load_bytes(cur_d);
      begin
        int k;
        k = 0;
        while (!done) begin
          case (mode)
            0:       tready = 1'b1;
            1:       tready = (k % 4 == 0) || (k % 4 == 3);
            default: tready = 1'($urandom_range(0, 1));
          endcase
          k++;
          @(posedge clk); #1;
        end
        tready = 1'b0;
      end
      begin
        while (!loaded && !done) begin @(posedge clk); #1; end
        repeat (delay) begin @(posedge clk); #1; end
        for (int k = 0; k < cur_a.size() && !done; k++) begin
          int w;
          w = 0;
          ans_valid = 1'b1; ans_data = cur_a[k]; ans_last_in = (k == cur_a.size() - 1);
          do begin @(negedge clk); w++; end while (!o_tmanager_ready && w < 400 && !done);
          if (o_tmanager_ready && ans_last_in) ans_last_cyc = cyc;
          @(posedge clk); #1;
          ans_valid = 1'b0; ans_last_in = 1'b0;
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
      begin
        int pv, pr, pd, ex;
        pv = 0; pr = 0; pd = 0;
        for (int t = 0; t < 4000 && !res_seen; t++) begin
          @(negedge clk);
          if (o_tdata_valid && first_cyc < 0) first_cyc = cyc;
          if (pv != 0 && pr == 0 && o_tdata_valid)
            check("hold_on_stall", int'({o_tdata_last, o_tdata}), pd);
          if (o_tdata_valid && tready) begin
            ex = (nsent < e_tx) ? int'({nsent == e_tx - 1, cur_d[nsent]}) : -1;
            check("send_byte", int'({o_tdata_last, o_tdata}), ex);
            nsent++;
            if (o_tdata_last) send_last = cyc;
          end
          if (ans_last_cyc >= 0 && cyc == ans_last_cyc + 1)
            check("mgr_ready_drop", int'(o_tmanager_ready), 0);
          if (o_result_valid) begin
            res_seen = 1; res_cyc = cyc;
            check("tx_count", int'(o_tx_count), e_tx);
            check("rx_count", int'(o_rx_count), e_rx);
            check("checksum", int'(o_checksum), e_cks);
            check("size_mismatch", int'(o_size_mismatch), e_mis);
            check("overflow", int'(o_overflow), e_ovf);
            check("timeout", int'(o_timeout), e_tmo);
          end
          pv = int'(o_tdata_valid); pr = int'(tready); pd = int'({o_tdata_last, o_tdata});
        end
        if (!res_seen) check("result_seen", 0, 1);
        done = 1;
      end
    join
    exp_res = (e_tmo != 0) ? send_last + TMO + 1
                           : ((send_last > ans_last_cyc) ? send_last : ans_last_cyc) + 1;
    check("result_latency", res_cyc, exp_res);
    check("first_byte_latency", first_cyc - load_last, 2);
    check("bytes_sent", nsent, e_tx);
    if (mode == 0) check("throughput", send_last - first_cyc + 1, e_tx);
    @(negedge clk);
    check("strobe_one_cycle", int'(o_result_valid), 0);
    check("result_hold", int'(o_tx_count), e_tx);
  endtask

  task automatic run_vec(input vec_t v);
    bq_t d, a;
    d.delete(); a.delete();
    for (int i = 0; i < v.len; i++) d.push_back(8'(v.base + i));
    for (int k = 0; k < v.n_ans; k++) a.push_back(v.ans[31 - 8 * k -: 8]);
    run_pkt(d, a, v.size, v.mode, v.delay, v.gap,
            v.e_tx, v.e_rx, v.e_cks, v.e_mis, v.e_ovf, v.e_tmo);
  endtask

  initial begin
    //          len base mode dly gap n  ans            size tx  rx cks                        mis ovf tmo
    vecs[0] = '{9,  1,    0,   5,  0, 4, 32'hA00BC00D, 4,   9,  4, 'hA0^'h0B^'hC0^'h0D,      0,  0,  0};
    vecs[1] = '{9,  1,    1,   5,  1, 4, 32'hA00BC00D, 4,   9,  4, 'hA0^'h0B^'hC0^'h0D,      0,  0,  0};
    vecs[2] = '{9,  1,    0,   0,  0, 4, 32'hA00BC00D, 4,   9,  4, 'hA0^'h0B^'hC0^'h0D,      0,  0,  0};
    vecs[3] = '{20, 'h30, 0,   3,  0, 2, 32'h55AA0000, 2,   16, 2, 'h55^'hAA,                0,  1,  0};
    vecs[4] = '{5,  'h10, 0,   0,  0, 0, 32'h0,        0,   5,  0, 0,                        0,  0,  1};
    vecs[5] = '{6,  'h40, 1,   2,  1, 3, 32'h11224400, 5,   6,  3, 'h11^'h22^'h44,           1,  0,  0};
    vecs[6] = '{1,  'h7E, 0,   2,  0, 1, 32'hC3000000, 1,   1,  1, 'hC3,                     0,  0,  0};
    vecs[7] = '{16, 'h80, 0,   4,  1, 3, 32'h01020400, 3,   16, 3, 'h01^'h02^'h04,           0,  0,  0};
    vecs[8] = '{4,  'h20, 0,   0,  0, 4, 32'hF00F33C0, 4,   4,  4, 'hF0^'h0F^'h33^'hC0,      0,  0,  0};
    vecs[9] = '{2,  'h90, 0,   8,  2, 2, 32'h5AA50000, 3,   2,  2, 'h5A^'hA5,                1,  0,  0};

    repeat (3) @(negedge clk);
    check("reset_src_ready", int'(o_src_ready), 0);
    check("reset_outputs", outs_nonzero(), 0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_reset_src_ready", int'(o_src_ready), 1);
    check("post_reset_no_strobe", int'(o_result_valid), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while SEND is stalled on byte 0.
    begin
      bq_t d;
      d.delete();
      for (int i = 0; i < 5; i++) d.push_back(8'(8'hE0 + i));
      @(posedge clk); #1;
      tready = 1'b0; loaded = 0;
      load_bytes(d);
      repeat (3) @(negedge clk);
      check("mid_send_valid", int'(o_tdata_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_send_reset_outputs", outs_nonzero(), 0);
      repeat (3) begin
        @(negedge clk);
        check("reset_no_strobe", int'(o_result_valid), 0);
      end
      #2 rst = 1'b0;
      @(negedge clk);
      check("after_reset_src_ready", int'(o_src_ready), 1);
      check("after_reset_no_strobe", int'(o_result_valid), 0);
      run_vec(vecs[0]);
    end

    for (int r = 0; r < 14; r++) begin
      bq_t d, a;
      int len, na, sz, tx, rx, cks, mis, ovf, tmo;
      d.delete(); a.delete();
      len = $urandom_range(1, 24);
      na  = $urandom_range(0, 4);
      sz  = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      for (int k = 0; k < na; k++) a.push_back(8'($urandom));
      model(d, a, sz, tx, rx, cks, mis, ovf, tmo);
      run_pkt(d, a, sz, $urandom_range(0, 2), $urandom_range(0, 8), $urandom_range(0, 2),
              tx, rx, cks, mis, ovf, tmo);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
